// File: rtl/multicycle_mem_responder_if.sv
// Memory request/response bundle between the multicycle control FSM (master)
// and the unified instruction/data memory responder (slave).
interface multicycle_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) ();
    logic              I_MEM_ENABLE;
    logic              I_INSTRUCTION_OR_DATA;
    logic              I_MEM_WRITE;
    logic [ADDR_W-1:0] I_PC;
    logic [ADDR_W-1:0] I_DATA_ADDR;
    logic [DATA_W-1:0] I_WRITE_DATA;
    logic              I_IR_WRITE;
    logic [DATA_W-1:0] O_READ_DATA;
    logic              O_MEM_READY;
    logic              O_BUSY;
    logic [DATA_W-1:0] O_INSTRUCTION;
    logic [5:0]        O_OPCODE;
    logic [5:0]        O_OP_FUNCTION;

    modport master (
        output I_MEM_ENABLE, I_INSTRUCTION_OR_DATA, I_MEM_WRITE, I_PC, I_DATA_ADDR,
               I_WRITE_DATA, I_IR_WRITE,
        input  O_READ_DATA, O_MEM_READY, O_BUSY, O_INSTRUCTION, O_OPCODE, O_OP_FUNCTION
    );

    modport slave (
        input  I_MEM_ENABLE, I_INSTRUCTION_OR_DATA, I_MEM_WRITE, I_PC, I_DATA_ADDR,
               I_WRITE_DATA, I_IR_WRITE,
        output O_READ_DATA, O_MEM_READY, O_BUSY, O_INSTRUCTION, O_OPCODE, O_OP_FUNCTION
    );
endinterface

// File: rtl/multicycle_mem_responder.sv
// Unified instruction/data memory for the multicycle CPU: captures one request,
// waits WAIT_CYCLES, completes with a one-cycle ready pulse, and holds the IR.
module multicycle_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_mem_responder_if.slave  mem_bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_we;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        ready_d     = 1'b0;
        instr_d     = instr_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        mem_we      = 1'b0;

        if (mem_bus.I_IR_WRITE && ready_q) begin
            instr_d = read_data_q;
        end

        case (state_q)
            S_IDLE: begin
                // The ready cycle itself never re-accepts a still-held enable.
                if (mem_bus.I_MEM_ENABLE && !ready_q) begin
                    addr_d  = mem_bus.I_INSTRUCTION_OR_DATA ? mem_bus.I_DATA_ADDR : mem_bus.I_PC;
                    write_d = mem_bus.I_MEM_WRITE;
                    wdata_d = mem_bus.I_WRITE_DATA;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        read_data_d = mem[addr_q];
                    end
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            instr_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            instr_q     <= instr_d;
        end
    end

    // NOTE: the array and the captured request are deliberately not reset; only the
    // control state is. Reset still blocks a pending store so an aborted access commits nothing.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        write_q <= write_d;
        wdata_q <= wdata_d;
        if (mem_we && !reset) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign mem_bus.O_READ_DATA   = read_data_q;
    assign mem_bus.O_MEM_READY   = ready_q;
    assign mem_bus.O_BUSY        = (state_q == S_BUSY);
    assign mem_bus.O_INSTRUCTION = instr_q;
    assign mem_bus.O_OPCODE      = instr_q[31:26];
    assign mem_bus.O_OP_FUNCTION = instr_q[5:0];
endmodule
